// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Control FSM for a three-button "whack the front monster" game. It keeps a
// six-deep shadow of the picture queue held in the external datapath, requests
// random monster types to keep that queue full, judges button presses against
// the front monster, and drives load/shift/clear strobes for the datapath.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   btn1..btn3   one-cycle debounced press pulses
//   start        one-cycle pulse, starts/restarts a game from IDLE or FINISH
//   rnd_valid    rnd_num valid this cycle
//   rnd_num      random monster type (3 is rejected)
//   need_random  request to the random generator
//   load         write load_type into datapath slot 5
//   load_type    monster type for the tail slot
//   shift        advance the datapath queue one slot toward slot 0
//   clear        zero all datapath picture registers
//   front_type   type of the monster in slot 0 (0 when queue empty)
//   score        hit counter, saturates at 255
//   misses       miss counter
//   gameover     high while in FINISH
//   state        current FSM state
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | after reset, waiting for start
// READY  | filling the queue with six monsters
// GAMING | judging presses against the front monster, refilling as it drains
// FINISH | miss limit reached, waiting for start
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module game_sequencer #(
  parameter logic [23:0] TIMEOUT  = 24'd12_000_000,
  parameter logic [1:0]  MAX_MISS = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       start,
  input  logic       rnd_valid,
  input  logic [1:0] rnd_num,
  output logic       need_random,
  output logic       load,
  output logic [1:0] load_type,
  output logic       shift,
  output logic       clear,
  output logic [1:0] front_type,
  output logic [7:0] score,
  output logic [1:0] misses,
  output logic       gameover,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READY  = 2'd1,
    ST_GAMING = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [1:0]  r_q [6];
  logic [1:0]  w_q_upd [6];
  logic [1:0]  w_q_next [6];
  logic [2:0]  r_cnt, w_cnt_mid, w_cnt_upd, w_cnt_next;
  logic [23:0] r_timer, w_timer_next;
  logic [7:0]  r_score, w_score_next;
  logic [1:0]  r_misses, w_misses_next;
  logic        r_load, w_load_next;
  logic [1:0]  r_load_type, w_load_type_next;
  logic        r_shift, w_shift_next;
  logic        r_shift_d;
  logic        r_clear, w_clear_next;
  logic        w_flush;

  logic        w_active, w_need, w_accept;
  logic        w_judge, w_hit, w_miss, w_timeout, w_btn_sel, w_last_miss;
  logic [1:0]  w_nbtn, w_front;
  logic [2:0]  w_occ;

  assign w_front   = (r_cnt == 3'd0) ? 2'd0 : r_q[0];
  assign w_active  = (r_state == ST_READY) || (r_state == ST_GAMING);
  // a registered load not yet applied already owns a slot
  assign w_occ     = r_cnt + {2'b00, r_load};
  assign w_need    = w_active && (w_occ < 3'd6);
  assign w_accept  = w_need && rnd_valid && (rnd_num != 2'd3);

  assign w_nbtn    = {1'b0, btn1} + {1'b0, btn2} + {1'b0, btn3};
  always_comb begin
    w_btn_sel = 1'b0;
    case (w_front)
      2'd0:    w_btn_sel = btn1;
      2'd1:    w_btn_sel = btn2;
      2'd2:    w_btn_sel = btn3;
      default: w_btn_sel = 1'b0;
    endcase
  end

  // While a shift is in flight (and the cycle after) slot 0 still shows or has
  // just replaced the judged monster, so presses there are not judged.
  assign w_judge     = (r_state == ST_GAMING) && (r_cnt != 3'd0) && !r_shift && !r_shift_d;
  assign w_timeout   = (r_timer == TIMEOUT - 24'd1);
  assign w_hit       = w_judge && (w_nbtn == 2'd1) && w_btn_sel;
  assign w_miss      = w_judge && !w_hit && ((w_nbtn != 2'd0) || w_timeout);
  assign w_last_miss = ((r_misses + 2'd1) == MAX_MISS);

  // Shadow queue follows the datapath: pop on shift first, then append the load.
  always_comb begin
    w_q_upd   = r_q;
    w_cnt_mid = r_cnt;
    if (r_shift) begin
      for (int i = 0; i < 5; i++) w_q_upd[i] = r_q[i+1];
      w_q_upd[5] = 2'd0;
      w_cnt_mid  = r_cnt - 3'd1;
    end
    w_cnt_upd = w_cnt_mid;
    if (r_load) begin
      for (int i = 0; i < 6; i++) begin
        if (w_cnt_mid == 3'(i)) w_q_upd[i] = r_load_type;
      end
      w_cnt_upd = w_cnt_mid + 3'd1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_q_next         = w_q_upd;
    w_cnt_next       = w_cnt_upd;
    w_timer_next     = r_timer;
    w_score_next     = r_score;
    w_misses_next    = r_misses;
    w_load_next      = w_accept;
    w_load_type_next = w_accept ? rnd_num : 2'd0;
    w_shift_next     = 1'b0;
    w_clear_next     = 1'b0;
    w_flush          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_timer_next = 24'd0;
        if (start) begin
          w_state_next  = ST_READY;
          w_score_next  = 8'd0;
          w_misses_next = 2'd0;
          w_load_next   = 1'b0;
          w_flush       = 1'b1;
        end
      end
      ST_READY: begin
        w_timer_next = 24'd0;
        if (w_cnt_upd == 3'd6) w_state_next = ST_GAMING;
      end
      ST_GAMING: begin
        if (w_hit) begin
          w_score_next = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
          w_shift_next = 1'b1;
          w_timer_next = 24'd0;
        end else if (w_miss) begin
          w_misses_next = r_misses + 2'd1;
          w_timer_next  = 24'd0;
          if (w_last_miss) begin
            w_state_next     = ST_FINISH;
            w_clear_next     = 1'b1;
            w_load_next      = 1'b0;
            w_load_type_next = 2'd0;
            w_flush          = 1'b1;
          end else begin
            w_shift_next = 1'b1;
          end
        end else if (r_shift || (r_cnt == 3'd0)) begin
          w_timer_next = 24'd0;
        end else begin
          w_timer_next = r_timer + 24'd1;
        end
      end
      ST_FINISH: begin
        w_timer_next = 24'd0;
        if (start) begin
          w_state_next  = ST_READY;
          w_score_next  = 8'd0;
          w_misses_next = 2'd0;
          w_clear_next  = 1'b1;
          w_flush       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_flush) begin
      for (int i = 0; i < 6; i++) w_q_next[i] = 2'd0;
      w_cnt_next = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < 6; i++) r_q[i] <= 2'd0;
      r_cnt       <= 3'd0;
      r_timer     <= 24'd0;
      r_score     <= 8'd0;
      r_misses    <= 2'd0;
      r_load      <= 1'b0;
      r_load_type <= 2'd0;
      r_shift     <= 1'b0;
      r_shift_d   <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_q         <= w_q_next;
      r_cnt       <= w_cnt_next;
      r_timer     <= w_timer_next;
      r_score     <= w_score_next;
      r_misses    <= w_misses_next;
      r_load      <= w_load_next;
      r_load_type <= w_load_type_next;
      r_shift     <= w_shift_next;
      r_shift_d   <= r_shift;
      r_clear     <= w_clear_next;
    end
  end

  assign need_random = w_need;
  assign load        = r_load;
  assign load_type   = r_load_type;
  assign shift       = r_shift;
  assign clear       = r_clear;
  assign front_type  = w_front;
  assign score       = r_score;
  assign misses      = r_misses;
  assign gameover    = (r_state == ST_FINISH);
  assign state       = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Scoreboard bench for game_sequencer. A queue-based reference model predicts
// each cycle's outputs plus the load and shift events; a monitor pops and
// compares them after every rising edge. Directed scenarios are followed by a
// score-saturation run and a randomized play phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_sequencer;
  localparam int TO   = 10;
  localparam int MAXM = 3;

  logic       clk = 1'b0;
  logic       rst, btn1, btn2, btn3, start, rnd_valid;
  logic [1:0] rnd_num;
  logic       need_random, load, shift, clear, gameover;
  logic [1:0] load_type, front_type, misses, state;
  logic [7:0] score;

  game_sequencer #(.TIMEOUT(24'd10), .MAX_MISS(2'd3)) dut (
    .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2), .btn3(btn3),
    .start(start), .rnd_valid(rnd_valid), .rnd_num(rnd_num),
    .need_random(need_random), .load(load), .load_type(load_type),
    .shift(shift), .clear(clear), .front_type(front_type), .score(score),
    .misses(misses), .gameover(gameover), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_ptype, m_timer, m_score, m_miss;
  int mq[$];
  bit m_pload, m_shift, m_shift_prev;

  typedef struct { int st; int score; int miss; int front; int need; int gov; int clr; int ld; int sh; } snap_t;
  typedef struct { int score; int miss; } shev_t;
  snap_t snap_q[$];
  int    load_q[$];
  shev_t shift_q[$];
  int    obs_loads[$];

  task automatic model_reset();
    m_state = 0; mq.delete(); m_pload = 0; m_ptype = 0; m_shift = 0;
    m_shift_prev = 0; m_timer = 0; m_score = 0; m_miss = 0;
    snap_q.delete(); load_q.delete(); shift_q.delete();
  endtask

  function automatic int model_front();
    return (mq.size() > 0) ? mq[0] : 0;
  endfunction

  task automatic model_step(input bit b1, input bit b2, input bit b3,
                            input bit st, input bit rv, input int rn);
    bit need, accept, judge, hit, miss, n_shift, n_clear, n_pload;
    int n_ptype, nb, front;
    int nq[$];
    snap_t s;
    shev_t e;
    n_shift = 0; n_clear = 0;
    need   = (m_state == 1 || m_state == 2) && (mq.size() + int'(m_pload) < 6);
    accept = need && rv && (rn != 3);
    nq = mq;
    if (m_shift) void'(nq.pop_front());
    if (m_pload) nq.push_back(m_ptype);
    n_pload = accept;
    n_ptype = accept ? rn : 0;
    front = model_front();
    nb    = int'(b1) + int'(b2) + int'(b3);
    judge = (m_state == 2) && (mq.size() > 0) && !m_shift && !m_shift_prev;
    hit   = judge && (nb == 1) && ((front == 0 && b1) || (front == 1 && b2) || (front == 2 && b3));
    miss  = judge && !hit && (nb > 0 || m_timer == TO - 1);
    m_shift_prev = m_shift;
    case (m_state)
      0: begin
        m_timer = 0;
        if (st) begin m_state = 1; nq.delete(); m_score = 0; m_miss = 0; n_pload = 0; end
      end
      1: begin
        m_timer = 0;
        if (nq.size() == 6) m_state = 2;
      end
      2: begin
        if (hit) begin
          if (m_score < 255) m_score++;
          n_shift = 1; m_timer = 0;
        end else if (miss) begin
          m_miss++; m_timer = 0;
          if (m_miss == MAXM) begin
            m_state = 3; n_clear = 1; n_pload = 0; n_ptype = 0; nq.delete();
          end else n_shift = 1;
        end else if (m_shift || mq.size() == 0) m_timer = 0;
        else m_timer++;
      end
      default: begin
        m_timer = 0;
        if (st) begin m_state = 1; m_score = 0; m_miss = 0; n_clear = 1; nq.delete(); end
      end
    endcase
    mq = nq; m_shift = n_shift; m_pload = n_pload; m_ptype = n_ptype;
    if (n_pload) load_q.push_back(n_ptype);
    if (n_shift) begin e.score = m_score; e.miss = m_miss; shift_q.push_back(e); end
    s.st = m_state; s.score = m_score; s.miss = m_miss; s.front = model_front();
    s.need = int'((m_state == 1 || m_state == 2) && (mq.size() + int'(m_pload) < 6));
    s.gov = int'(m_state == 3); s.clr = int'(n_clear); s.ld = int'(n_pload); s.sh = int'(n_shift);
    snap_q.push_back(s);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    snap_t s;
    shev_t e;
    #1;
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      check("state", state, s.st);
      check("score", score, s.score);
      check("misses", misses, s.miss);
      check("front_type", front_type, s.front);
      check("need_random", need_random, s.need);
      check("gameover", gameover, s.gov);
      check("clear", clear, s.clr);
      check("load", load, s.ld);
      check("shift", shift, s.sh);
    end
    if (load === 1'b1) begin
      obs_loads.push_back(int'(load_type));
      if (load_q.size() == 0) check("load_unexpected", load, 0);
      else check("load_type", load_type, load_q.pop_front());
    end
    if (shift === 1'b1) begin
      if (shift_q.size() == 0) check("shift_unexpected", shift, 0);
      else begin
        e = shift_q.pop_front();
        check("shift_score", score, e.score);
        check("shift_misses", misses, e.miss);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit b1, input bit b2, input bit b3,
                     input bit st, input bit rv, input int rn);
    btn1 = b1; btn2 = b2; btn3 = b3; start = st; rnd_valid = rv; rnd_num = 2'(rn);
    model_step(b1, b2, b3, st, rv, rn);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_a[8];
    int exp_a[6];
    int n, f;
    seq_a = '{0, 1, 3, 2, 0, 3, 1, 2};
    exp_a = '{0, 1, 2, 0, 1, 2};
    rst = 1'b0; btn1 = 0; btn2 = 0; btn3 = 0; start = 0; rnd_valid = 0; rnd_num = 2'd0;
    model_reset();
    #1;
    check("rst_state", state, 0);
    check("rst_need", need_random, 0);
    check("rst_score", score, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // fill: rnd_num 3 values are discarded
    obs_loads.delete();
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, seq_a[i]);
    cyc(0, 0, 0, 0, 0, 0);
    check("fill_load_count", obs_loads.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_loads.size()) check("fill_load_order", obs_loads[i], exp_a[i]);
    end
    check("fill_state", state, 2);
    check("fill_need_low", need_random, 0);

    // two buttons at once on front type 0
    cyc(1, 0, 1, 0, 0, 0);
    check("dbl_misses", misses, 1);
    check("dbl_shift", shift, 1);
    check("dbl_score", score, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("dbl_shift_once", shift, 0);
    check("dbl_front_next", front_type, 1);

    // press right after the shift is ignored; refill one slot meanwhile
    cyc(0, 1, 0, 0, 1, 0);
    check("post_shift_score", score, 0);
    check("post_shift_misses", misses, 1);
    check("post_shift_need_full", need_random, 0);

    // correct button on front type 1
    cyc(0, 1, 0, 0, 0, 0);
    check("hit_score", score, 1);
    check("hit_shift", shift, 1);
    check("hit_need_low", need_random, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("hit_shift_once", shift, 0);
    check("hit_front_next", front_type, 2);
    check("hit_need_rise", need_random, 1);

    // timeouts: tenth cycle of each front monster
    idle(9);
    check("to1_not_yet", misses, 1);
    idle(1);
    check("to1_misses", misses, 2);
    check("to1_shift", shift, 1);
    idle(10);
    check("to2_not_yet", misses, 2);
    check("to2_state_not_yet", state, 2);
    idle(1);
    check("to2_state_finish", state, 3);
    check("to2_clear", clear, 1);
    check("to2_gameover", gameover, 1);
    check("to2_no_shift", shift, 0);
    check("to2_misses", misses, 3);
    idle(1);
    check("finish_clear_once", clear, 0);
    check("finish_gameover", gameover, 1);
    check("finish_need", need_random, 0);

    // restart from FINISH
    cyc(0, 0, 0, 1, 0, 0);
    check("restart_state", state, 1);
    check("restart_clear", clear, 1);
    check("restart_score", score, 0);
    check("restart_misses", misses, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("restart_clear_once", clear, 0);

    // reset in the middle of a refill
    n = 0;
    while (state !== 2'd2 && n < 40) begin
      cyc(0, 0, 0, 0, 1, $urandom_range(0, 2));
      n++;
    end
    check("refill_to_gaming", state, 2);
    f = model_front();
    cyc(f == 0, f == 1, f == 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check("mid_refill_load", load, 1);
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_need_random", need_random, 0);
    check("rst_load", load, 0);
    check("rst_load_type", load_type, 0);
    check("rst_shift", shift, 0);
    check("rst_clear", clear, 0);
    check("rst_gameover", gameover, 0);
    check("rst_front_type", front_type, 0);
    check("rst_score_mid", score, 0);
    check("rst_misses", misses, 0);
    check("rst_state_mid", state, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      check("post_rst_idle", state, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    check("post_rst_start", state, 1);

    // long winning run: score must saturate at 255
    for (int i = 0; i < 900; i++) begin
      f = model_front();
      cyc(f == 0, f == 1, f == 2, 0, 1, $urandom_range(0, 3));
    end
    check("sat_score", score, 255);
    check("sat_misses", misses, 0);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
    end
    idle(2);
    check("load_q_drained", load_q.size(), 0);
    check("shift_q_drained", shift_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 24'd12_000_000, cycles a front monster may wait before it counts as a miss.
REQ-002 The module SHALL have parameter MAX_MISS, default 2'd3, miss count that ends the game.
REQ-003 The module SHALL have port clk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have ports btn1, btn2, btn3, input, 1 each, debounced one-cycle press pulses.
REQ-006 The module SHALL have port start, input, 1, one-cycle pulse that starts or restarts a game.
REQ-007 The module SHALL have port rnd_valid, input, 1, marking rnd_num as valid this cycle.
REQ-008 The module SHALL have port rnd_num, input, 2, the random monster type.
REQ-009 The module SHALL have port need_random, output, 1, the request to the random generator.
REQ-010 The module SHALL have ports load, output, 1, and load_type, output, 2, which write a monster type into the datapath tail slot (slot 5).
REQ-011 The module SHALL have port shift, output, 1, which advances the datapath queue one slot toward slot 0.
REQ-012 The module SHALL have port clear, output, 1, which zeroes all datapath picture registers.
REQ-013 The module SHALL have ports front_type, output, 2; score, output, 8; misses, output, 2; gameover, output, 1; and state, output, 2.

Function
REQ-014 The FSM SHALL have exactly four states with these state encodings: IDLE=0, READY=1, GAMING=2, FINISH=3.
REQ-015 The module SHALL keep an internal 6-entry queue of 2-bit types plus a 3-bit count (0..6); front_type SHALL equal entry 0, or 0 when the count is 0.
REQ-016 IDLE: on start the FSM SHALL go to READY next cycle, clearing the queue, score, and misses.
REQ-017 need_random SHALL be combinational, high exactly when the state is READY or GAMING and count plus pending loads is less than 6.
REQ-018 A random value SHALL be accepted in a cycle where need_random is high, rnd_valid is 1, and rnd_num < 3.
REQ-019 A random value with rnd_num == 3 SHALL be discarded with no state change, and need_random SHALL stay high.
REQ-020 For an accept in cycle N, load SHALL be 1 and load_type SHALL equal rnd_num in cycle N+1 (registered), and the entry SHALL be appended to the queue tail.
REQ-021 READY SHALL go to GAMING in the cycle after the 6th accepted load; the front timer SHALL start at 0.
REQ-022 GAMING: the front timer SHALL increment each cycle while the count is at least 1.
REQ-023 Judgement SHALL occur only when count ≥ 1 and no shift was issued in the previous cycle; buttons outside these conditions SHALL be ignored.
REQ-024 A hit SHALL be exactly one button pressed, with btn(k+1) matching front_type k.
REQ-025 On a hit, score SHALL increment and saturate at 255.
REQ-026 A miss SHALL be a wrong single button, two or more buttons in the same cycle, or the timer reaching TIMEOUT-1; on a miss, misses SHALL increment.
REQ-027 On a hit or a miss, shift SHALL be 1 for exactly one cycle in the next cycle, the queue SHALL pop entry 0, the count SHALL decrement, and the timer SHALL reset to 0.
REQ-028 Shift and load MAY both be asserted in the same cycle; the datapath applies shift first, then writes slot 5, and the internal queue SHALL model the same order.
REQ-029 When a miss makes misses equal MAX_MISS, the FSM SHALL go to FINISH instead of issuing shift; pending loads SHALL be dropped.
REQ-030 FINISH: clear SHALL be 1 for the first cycle in FINISH only; gameover SHALL be 1 while in FINISH; need_random, load, and shift SHALL be 0.
REQ-031 On start in FINISH, the FSM SHALL go to READY, score and misses SHALL reset to 0, and clear SHALL pulse for one more cycle.
REQ-032 A start pulse SHALL be ignored in READY and GAMING.

Reset
REQ-033 When rst is low, the module SHALL immediately set state=IDLE, count=0, timer=0, score=0, misses=0, and set need_random, load, load_type, shift, clear, gameover, and front_type to 0.
REQ-034 A reset asserted in any state, including mid-refill or mid-shift, SHALL abandon all pending load and shift operations.

Verification
REQ-035 The bench SHALL check: start, then 8 rnd_valid pulses with rnd_num=0,1,3,2,0,3,1,2 -> exactly 6 load pulses with types 0,1,2,0,1,2, need_random low afterward, state=2.
REQ-036 The bench SHALL check: in GAMING with front_type=1, a btn2 pulse -> score=1, a one-cycle shift in the next cycle, front_type becomes 2, need_random rises.
REQ-037 The bench SHALL check: btn1 and btn3 pressed in the same cycle -> misses=1, shift, score unchanged.
REQ-038 The bench SHALL check: TIMEOUT=10 and no buttons -> a miss at cycle 10 of the front monster; the third miss -> state=3, one-cycle clear, gameover=1, no shift.
REQ-039 The bench SHALL check: a button pulse in the cycle directly after shift -> ignored; score and misses unchanged.
REQ-040 The bench SHALL check: rst low mid-refill in GAMING -> all outputs 0 in the same cycle; after release, state=0 until start.
